// File: rtl/wb_pipe_buf_if.sv
// Writeback buffer handshake bundle: MEM-side push channel and register-file-side pop channel.
// The slave modport is the buffer's view; master is the surrounding pipeline's view.
interface wb_pipe_buf_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 2
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES-1:0]          in_we;
    logic [LANES*ADDR_W-1:0]   in_waddr;
    logic [LANES*DATA_W-1:0]   in_wdata;
    logic                      wb_ready;
    logic                      wb_valid;
    logic [LANES-1:0]          wb_we;
    logic [LANES*ADDR_W-1:0]   wb_waddr;
    logic [LANES*DATA_W-1:0]   wb_wdata;

    modport slave (
        input  in_valid, in_we, in_waddr, in_wdata, wb_ready,
        output in_ready, wb_valid, wb_we, wb_waddr, wb_wdata
    );

    modport master (
        output in_valid, in_we, in_waddr, in_wdata, wb_ready,
        input  in_ready, wb_valid, wb_we, wb_waddr, wb_wdata
    );
endinterface

// File: rtl/wb_pipe_buf.sv
// MEM/WB stage: DEPTH-entry FIFO of LANES-wide writeback bundles with flush,
// r0 suppression, youngest-lane-wins address resolution and a saturating retire counter.
module wb_pipe_buf #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int LANES  = 2,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    wb_pipe_buf_if.slave       bus,
    output logic [CNT_W-1:0]   retire_cnt
);
    localparam int              PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]  CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W:0]             r_count;
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_retire;
    logic [LANES-1:0]           r_we_mem   [DEPTH];
    logic [LANES*ADDR_W-1:0]    r_addr_mem [DEPTH];
    logic [LANES*DATA_W-1:0]    r_data_mem [DEPTH];

    logic                       w_full;
    logic                       w_valid;
    logic                       w_push;
    logic                       w_pop;
    logic [LANES-1:0]           w_base_we;
    logic [LANES-1:0]           w_kill;
    logic [LANES-1:0]           w_push_we;
    logic [LANES-1:0]           w_head_we;
    logic [CNT_W-1:0]           w_pop_cnt;
    logic [CNT_W:0]             w_sum;

    assign w_full  = (r_count == CNT_FULL);
    assign w_valid = (r_count != '0);
    assign w_push  = bus.in_valid & ~w_full & ~flush;
    assign w_pop   = w_valid & bus.wb_ready & ~flush;

    // Masking is resolved once at push so the head entry can be popped without recomputation.
    always_comb begin
        w_base_we = '0;
        w_kill    = '0;
        for (int i = 0; i < LANES; i++) begin
            w_base_we[i] = bus.in_we[i] && (bus.in_waddr[i*ADDR_W +: ADDR_W] != '0);
        end
        for (int i = 0; i < LANES; i++) begin
            for (int j = i + 1; j < LANES; j++) begin
                if (w_base_we[j] &&
                    (bus.in_waddr[j*ADDR_W +: ADDR_W] == bus.in_waddr[i*ADDR_W +: ADDR_W]))
                    w_kill[i] = 1'b1;
            end
        end
        w_push_we = w_base_we & ~w_kill;
    end

    assign w_head_we = w_valid ? r_we_mem[r_rd_ptr] : '0;

    always_comb begin
        w_pop_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            w_pop_cnt = w_pop_cnt + CNT_W'(w_head_we[i]);
        end
        w_sum = {1'b0, r_retire} + {1'b0, w_pop_cnt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_retire <= '0;
        end else if (flush) begin
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
            else if (w_pop && !w_push) r_count <= r_count - (PTR_W+1)'(1);
            if (w_pop) r_retire <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
        end
    end

    // Storage needs no reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_we_mem[r_wr_ptr]   <= w_push_we;
            r_addr_mem[r_wr_ptr] <= bus.in_waddr;
            r_data_mem[r_wr_ptr] <= bus.in_wdata;
        end
    end

    assign bus.in_ready = ~w_full;
    assign bus.wb_valid = w_valid;
    assign bus.wb_we    = w_head_we;
    assign bus.wb_waddr = r_addr_mem[r_rd_ptr];
    assign bus.wb_wdata = r_data_mem[r_rd_ptr];
    assign retire_cnt   = r_retire;
endmodule
